// File: rtl/stream_cipher_pkg.sv
// Shared constants for the wide stream cipher: AES S-box keystream table and
// character/key/counter widths used by the RTL and its testbenches.
package stream_cipher_pkg;

  localparam int KEY_W  = 8;
  localparam int CHAR_W = 8;
  localparam int CTR_W  = 8;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/stream_cipher_lane.sv
// One cipher lane: XORs a character with the S-box entry selected by
// key + counter + lane index (8-bit wrapping offset).
module stream_cipher_lane
  import stream_cipher_pkg::*;
(
  input  logic [KEY_W-1:0]  key_q,
  input  logic [CTR_W-1:0]  ctr_q,
  input  logic [CTR_W-1:0]  lane_idx,
  input  logic [CHAR_W-1:0] char_in,
  output logic [CHAR_W-1:0] char_out
);

  logic [7:0] sbox_idx;

  // NOTE: every signal written in an always_comb is assigned on every path,
  // so no latch can be inferred.
  always_comb begin
    sbox_idx = key_q + ctr_q + lane_idx;
    char_out = char_in ^ SBOX[sbox_idx];
  end

endmodule

// File: rtl/stream_cipher_wide.sv
// Multi-lane stream cipher: LANES characters per beat, keystream counter,
// and a 2-entry output FIFO with valid/ready backpressure.
module stream_cipher_wide
  import stream_cipher_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CNT_W = $clog2(LANES + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       key_in,
  input  logic [KEY_W-1:0]           key,
  input  logic                       din_valid,
  output logic                       din_ready,
  input  logic [CHAR_W*LANES-1:0]    din_data,
  input  logic [CNT_W-1:0]           din_cnt,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [CHAR_W*LANES-1:0]    dout_data,
  output logic [CNT_W-1:0]           dout_cnt
);

  localparam int               DATA_W  = CHAR_W * LANES;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(LANES);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  cnt;
  } beat_t;

  logic [KEY_W-1:0]  key_q;
  logic [CTR_W-1:0]  ctr_q;
  beat_t             fifo_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        occ_q;

  logic [CNT_W-1:0]  n_lanes;
  logic [DATA_W-1:0] ks_data;
  logic [DATA_W-1:0] beat_data;
  logic              accept;
  logic              push;
  logic              pop;

  assign n_lanes    = (din_cnt > MAX_CNT) ? MAX_CNT : din_cnt;
  assign din_ready  = (occ_q != 2'd2) && !key_in;
  assign accept     = din_valid && din_ready;
  // Empty beats are consumed but never occupy a FIFO slot.
  assign push       = accept && (n_lanes != '0);
  assign dout_valid = (occ_q != 2'd0);
  assign pop        = dout_valid && dout_ready;
  assign dout_data  = fifo_q[rd_ptr_q].data;
  assign dout_cnt   = fifo_q[rd_ptr_q].cnt;

  generate
    for (genvar j = 0; j < LANES; j++) begin : g_lane
      localparam logic [CTR_W-1:0] IDX = CTR_W'(j);

      stream_cipher_lane u_lane (
        .key_q    (key_q),
        .ctr_q    (ctr_q),
        .lane_idx (IDX),
        .char_in  (din_data[CHAR_W*j +: CHAR_W]),
        .char_out (ks_data[CHAR_W*j +: CHAR_W])
      );

      assign beat_data[CHAR_W*j +: CHAR_W] =
        (CNT_W'(j) < n_lanes) ? ks_data[CHAR_W*j +: CHAR_W] : '0;
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= '0;
      ctr_q <= '0;
    end else if (key_in) begin
      key_q <= key;
      ctr_q <= '0;
    end else if (accept) begin
      ctr_q <= ctr_q + CTR_W'(n_lanes);
    end
  end

  // NOTE: the FIFO storage is reset because its head drives dout_data/dout_cnt,
  // which must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= '{data: beat_data, cnt: n_lanes};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_cipher_wide.sv
// Randomised and directed bench for stream_cipher_wide (LANES=4) against a
// queue-based reference model of the cipher and its 2-deep output buffer.
module tb_stream_cipher_wide;
  import stream_cipher_pkg::*;

  localparam int LANES = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             key_in = 1'b0;
  logic [7:0]       key = '0;
  logic             din_valid = 1'b0;
  logic             din_ready;
  logic [31:0]      din_data = '0;
  logic [CNT_W-1:0] din_cnt = '0;
  logic             dout_valid;
  logic             dout_ready = 1'b0;
  logic [31:0]      dout_data;
  logic [CNT_W-1:0] dout_cnt;

  always #5 clk = ~clk;

  stream_cipher_wide #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key        (key),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din_data   (din_data),
    .din_cnt    (din_cnt),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data),
    .dout_cnt   (dout_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: key, character count since key load, queue of pending beats.
  typedef struct {
    logic [31:0] data;
    int          cnt;
  } beat_t;

  beat_t      mq[$];
  int         m_key = 0;
  int         m_ctr = 0;
  logic [7:0] src_buf [256];
  logic [7:0] out_buf [256];
  logic [7:0] pt_buf  [256];
  int         out_pos = 0;
  bit         last_acc = 1'b0;

  function automatic logic [31:0] cipher(input int k, input int c, input logic [31:0] d, input int n);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < n; j++) r[8*j +: 8] = d[8*j +: 8] ^ SBOX[(k + c + j) % 256];
    return r;
  endfunction

  task automatic step(input bit kin, input logic [7:0] kv, input bit dv,
                      input logic [31:0] dd, input int dc, input bit dr);
    bit    exp_ready;
    bit    acc;
    bit    do_pop;
    int    n;
    beat_t b;
    @(negedge clk);
    key_in = kin; key = kv; din_valid = dv; din_data = dd;
    din_cnt = CNT_W'(dc); dout_ready = dr;
    #1;
    exp_ready = (mq.size() < 2) && !kin;
    check("din_ready", din_ready, exp_ready);
    check("dout_valid", dout_valid, mq.size() != 0);
    acc      = dv && exp_ready;
    do_pop   = dr && (mq.size() != 0);
    last_acc = acc;
    if (do_pop) begin
      b = mq.pop_front();
      check("dout_data", dout_data, b.data);
      check("dout_cnt", dout_cnt, b.cnt);
      for (int j = 0; j < b.cnt; j++)
        if (out_pos + j < 256) out_buf[out_pos + j] = dout_data[8*j +: 8];
      out_pos += b.cnt;
    end
    if (kin) begin
      m_key = kv;
      m_ctr = 0;
    end else if (acc) begin
      n = (dc > LANES) ? LANES : dc;
      if (n > 0) begin
        b.data = cipher(m_key, m_ctr, dd, n);
        b.cnt  = n;
        mq.push_back(b);
      end
      m_ctr = (m_ctr + n) % 256;
    end
  endtask

  task automatic peek(input string tag, input logic [31:0] ed, input logic [2:0] ec);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, dout_valid, 1);
    check({tag, "_data"}, dout_data, ed);
    check({tag, "_cnt"}, dout_cnt, ec);
  endtask

  task automatic drain();
    repeat (3) step(0, 8'h00, 0, 32'h0, 0, 1);
  endtask

  task automatic run_stream(input logic [7:0] k);
    int          in_pos;
    int          guard;
    int          c;
    logic [31:0] dd;
    in_pos = 0;
    guard  = 0;
    step(1, k, 0, 32'h0, 0, 1);
    out_pos = 0;
    while ((in_pos < 256 || mq.size() != 0) && guard < 3000) begin
      c = $urandom_range(0, 7);
      if (c > 256 - in_pos) c = 256 - in_pos;
      dd = '0;
      for (int j = 0; j < 4; j++)
        if (in_pos + j < 256) dd[8*j +: 8] = src_buf[in_pos + j];
      step(0, 8'h00, in_pos < 256, dd, c, $urandom_range(0, 3) != 0);
      if (last_acc) in_pos += (c > 4) ? 4 : c;
      guard++;
    end
    check("stream_done", guard < 3000, 1);
    check("stream_len", out_pos, 256);
  endtask

  initial begin
    logic [31:0] held_data;
    logic [2:0]  held_cnt;

    #12;
    check("rst_dout_valid", dout_valid, 0);
    check("rst_dout_data", dout_data, 0);
    check("rst_dout_cnt", dout_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_din_ready", din_ready, 1);

    // Full beats at key 0x00.
    step(1, 8'h00, 0, 32'h0, 0, 1);
    step(0, 8'h00, 1, 32'h03020100, 4, 0);
    peek("full0", 32'h78757d63, 3'd4);
    step(0, 8'h00, 1, 32'h0, 4, 1);
    peek("full1", 32'hc56f6bf2, 3'd4);
    drain();

    // Keystream offset wraps past 0xFF.
    step(1, 8'hfe, 0, 32'h0, 0, 1);
    step(0, 8'h00, 1, 32'h0, 4, 0);
    peek("wrap0", 32'h7c6316bb, 3'd4);
    step(0, 8'h00, 1, 32'h0, 4, 1);
    peek("wrap1", 32'h6bf27b77, 3'd4);
    drain();

    // Partial beat, then empty and oversized counts continue from offset 6.
    step(1, 8'h00, 0, 32'h0, 0, 1);
    step(0, 8'h00, 1, 32'h0, 2, 0);
    peek("part0", 32'h00007c63, 3'd2);
    step(0, 8'h00, 1, 32'h0, 4, 1);
    peek("part1", 32'h6bf27b77, 3'd4);
    drain();
    step(0, 8'h00, 1, 32'h0, 0, 1);
    @(posedge clk);
    #1;
    check("empty_no_out", dout_valid, 0);
    step(0, 8'h00, 1, 32'h0, 7, 0);
    peek("oversize", 32'h0130c56f, 3'd4);
    drain();

    // Backpressure: third beat refused, head held while stalled.
    step(0, 8'h00, 1, $urandom, 4, 0);
    step(0, 8'h00, 1, $urandom, 3, 0);
    held_data = dout_data;
    held_cnt  = dout_cnt;
    step(0, 8'h00, 1, $urandom, 4, 0);
    check("bp_full_ready", din_ready, 0);
    step(0, 8'h00, 0, 32'h0, 0, 0);
    check("bp_hold_data", dout_data, held_data);
    check("bp_hold_cnt", dout_cnt, held_cnt);
    drain();

    // Key reload mid-stream; new key 0x10 restarts at offset 0.
    step(1, 8'h00, 0, 32'h0, 0, 1);
    step(0, 8'h00, 1, $urandom, 4, 1);
    step(0, 8'h00, 1, $urandom, 2, 1);
    step(1, 8'h10, 1, 32'h0, 4, 1);
    step(0, 8'h00, 1, 32'h0, 4, 0);
    peek("rekey", 32'h7dc982ca, 3'd4);
    drain();

    // Asynchronous reset with beats in flight.
    step(0, 8'h00, 1, $urandom, 4, 0);
    step(0, 8'h00, 1, $urandom, 4, 0);
    @(negedge clk);
    din_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_dout_valid", dout_valid, 0);
    check("arst_dout_data", dout_data, 0);
    check("arst_dout_cnt", dout_cnt, 0);
    mq.delete();
    m_key = 0;
    m_ctr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 8'h00, 0, 32'h0, 0, 1);

    // Sweep all keys over 256 random characters; round-trip every 8th key.
    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < 256; i++) src_buf[i] = 8'($urandom);
      run_stream(8'(k));
      if (k % 8 == 0) begin
        pt_buf  = src_buf;
        src_buf = out_buf;
        run_stream(8'(k));
        for (int i = 0; i < 256; i++) check("roundtrip", out_buf[i], pt_buf[i]);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
